// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the core data port, the external requester and dmem.
// slave: arbiter side; master: surrounding core/ext/memory environment.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;

  logic          ext_valid;
  logic          ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_last;
  logic          ext_ready;
  logic          ext_rvalid;
  logic [DW-1:0] ext_rdata;

  logic          mem_we;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  ext_valid, ext_we, ext_addr, ext_wdata, ext_last,
    output ext_ready, ext_rvalid, ext_rdata,
    output mem_we, mem_a, mem_wd,
    input  mem_rd
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output ext_valid, ext_we, ext_addr, ext_wdata, ext_last,
    input  ext_ready, ext_rvalid, ext_rdata,
    input  mem_we, mem_a, mem_wd,
    output mem_rd
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: core has priority, a starvation counter guarantees the
// external port service, and external bursts may lock the memory up to MAX_BURST beats.
module dmem_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_WAIT  = 4,
  parameter int MAX_BURST = 8
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);
  localparam logic [BW-1:0] BEAT_LAST = BW'(MAX_BURST - 1);

  typedef enum logic {S_CPU, S_EXT} state_t;

  state_t        state, state_nx;
  logic [WW-1:0] wait_cnt, wait_nx;
  logic [BW-1:0] beat_cnt, beat_nx;
  logic          ext_gnt;
  logic          rvalid_q;
  logic [DW-1:0] rdata_q;
  logic [AW-1:0] mux_a;
  logic [DW-1:0] mux_wd;
  logic          mux_we;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_CPU;
      wait_cnt <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
      beat_cnt <= beat_nx;
    end
  end

  // Grant decision and next state; a bubble in S_EXT hands the cycle to the core
  // without releasing the lock.
  always_comb begin
    ext_gnt  = 1'b0;
    state_nx = state;
    beat_nx  = beat_cnt;
    wait_nx  = wait_cnt;
    unique case (state)
      S_CPU: begin
        ext_gnt = bus.ext_valid && (!bus.cpu_req || wait_cnt == WAIT_MAX);
        if (ext_gnt && !bus.ext_last && (MAX_BURST > 1)) begin
          state_nx = S_EXT;
          beat_nx  = BW'(1);
        end
      end
      S_EXT: begin
        ext_gnt = bus.ext_valid;
        if (ext_gnt) begin
          if (bus.ext_last || beat_cnt == BEAT_LAST) begin
            state_nx = S_CPU;
            beat_nx  = '0;
          end else begin
            beat_nx = beat_cnt + BW'(1);
          end
        end
      end
      default: begin
        state_nx = S_CPU;
        beat_nx  = '0;
      end
    endcase

    if (ext_gnt || !bus.ext_valid) begin
      wait_nx = '0;
    end else if (state == S_CPU && bus.cpu_req && wait_cnt != WAIT_MAX) begin
      wait_nx = wait_cnt + WW'(1);
    end
  end

  always_comb begin
    mux_a  = bus.cpu_addr;
    mux_wd = bus.cpu_wdata;
    mux_we = bus.cpu_req & bus.cpu_we;
    if (ext_gnt) begin
      mux_a  = bus.ext_addr;
      mux_wd = bus.ext_wdata;
      mux_we = bus.ext_we;
    end
  end

  // Read data is captured at acceptance; rdata holds between reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= ext_gnt & ~bus.ext_we;
      if (ext_gnt && !bus.ext_we) begin
        rdata_q <= bus.mem_rd;
      end
    end
  end

  assign bus.mem_a      = mux_a;
  assign bus.mem_wd     = mux_wd;
  assign bus.mem_we     = mux_we;
  assign bus.ext_ready  = ext_gnt;
  assign bus.cpu_stall  = bus.cpu_req & ext_gnt;
  assign bus.cpu_rdata  = bus.mem_rd;
  assign bus.ext_rvalid = rvalid_q;
  assign bus.ext_rdata  = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random traffic,
// compared every cycle against a behavioural arbitration model and a reference memory.
module tb_dmem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAX_WAIT  = 4;
  localparam int MAX_BURST = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Environment memory (combinational read, clocked write) and the reference copy
  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  assign bus.mem_rd = mem[bus.mem_a[9:2]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_a[9:2]] <= bus.mem_wd;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model: is the memory locked to ext, how long has ext been denied, beats so far
  bit          m_locked;
  int          m_denied;
  int          m_beats;
  logic        exp_rvalid;
  logic [31:0] exp_rdata;

  logic        obs_we, obs_stall, obs_ready;
  logic [31:0] obs_a, obs_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked   = 1'b0;
    m_denied   = 0;
    m_beats    = 0;
    exp_rvalid = 1'b0;
    exp_rdata  = '0;
  endtask

  function automatic bit ext_wins();
    return bus.ext_valid && (m_locked || !bus.cpu_req || m_denied >= MAX_WAIT);
  endfunction

  task automatic drive(input bit cr, input bit cw, input logic [31:0] ca, input logic [31:0] cd,
                       input bit ev, input bit ew, input logic [31:0] ea, input logic [31:0] ed,
                       input bit el);
    bus.cpu_req   = cr;
    bus.cpu_we    = cw;
    bus.cpu_addr  = ca;
    bus.cpu_wdata = cd;
    bus.ext_valid = ev;
    bus.ext_we    = ew;
    bus.ext_addr  = ea;
    bus.ext_wdata = ed;
    bus.ext_last  = el;
  endtask

  task automatic model_update(input bit win);
    if (reset && win && !bus.ext_we) begin
      exp_rvalid = 1'b1;
      exp_rdata  = ref_mem[bus.ext_addr[9:2]];
    end else if (reset) begin
      exp_rvalid = 1'b0;
    end
    if (win && bus.ext_we) ref_mem[bus.ext_addr[9:2]] = bus.ext_wdata;
    else if (!win && bus.cpu_req && bus.cpu_we) ref_mem[bus.cpu_addr[9:2]] = bus.cpu_wdata;
    if (!reset) return;
    if (win) begin
      m_denied = 0;
      if (!m_locked) begin
        if (!bus.ext_last && MAX_BURST > 1) begin
          m_locked = 1'b1;
          m_beats  = 1;
        end
      end else begin
        m_beats++;
        if (bus.ext_last || m_beats >= MAX_BURST) begin
          m_locked = 1'b0;
          m_beats  = 0;
        end
      end
    end else if (!bus.ext_valid) begin
      m_denied = 0;
    end else if (bus.cpu_req && m_denied < MAX_WAIT) begin
      m_denied++;
    end
  endtask

  // One clock: check combinational outputs mid-cycle, advance model at the edge,
  // then check registered read return just after the edge.
  task automatic cycle();
    bit          win;
    logic [31:0] ea, ed;
    logic        ew;
    #2;
    win = ext_wins();
    ea  = win ? bus.ext_addr  : bus.cpu_addr;
    ed  = win ? bus.ext_wdata : bus.cpu_wdata;
    ew  = win ? bus.ext_we    : (bus.cpu_req & bus.cpu_we);
    obs_we = bus.mem_we; obs_a = bus.mem_a; obs_stall = bus.cpu_stall;
    obs_ready = bus.ext_ready; obs_rdata = bus.cpu_rdata;
    chk("ext_ready", obs_ready, win);
    chk("cpu_stall", obs_stall, bus.cpu_req & win);
    chk("mem_we", obs_we, ew);
    chk("mem_a", obs_a, ea);
    if (ew) chk("mem_wd", bus.mem_wd, ed);
    chk("cpu_rdata", obs_rdata, ref_mem[ea[9:2]]);
    @(posedge clk);
    model_update(win);
    #1;
    chk("ext_rvalid", bus.ext_rvalid, exp_rvalid);
    chk("ext_rdata", bus.ext_rdata, exp_rdata);
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
  endtask

  initial begin
    int b, stalls, gap, diffs;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 32'h1000_0000 + i * 3;
      ref_mem[i] = 32'h1000_0000 + i * 3;
    end
    mem[4]     = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;

    // Reset state: counters clear, core wins against a pending ext request
    reset = 1'b0;
    model_reset();
    drive(1, 0, 32'h0, 0, 1, 0, 32'h10, 0, 1);
    @(posedge clk); #1;
    chk("rst_rvalid", bus.ext_rvalid, 0);
    chk("rst_rdata", bus.ext_rdata, 0);
    cycle();
    chk("rst_ready", obs_ready, 0);
    chk("rst_stall", obs_stall, 0);
    reset = 1'b1;
    idle();

    // Core-only store then load
    drive(1, 1, 32'h64, 32'h07, 0, 0, 0, 0, 0);
    cycle();
    chk("core_st_we", obs_we, 1);
    chk("core_st_a", obs_a, 32'h64);
    chk("core_st_stall", obs_stall, 0);
    drive(1, 0, 32'h64, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("core_ld", obs_rdata, 32'h07);

    // Idle core, single ext read
    drive(0, 0, 0, 0, 1, 0, 32'h10, 0, 1);
    cycle();
    chk("ext_rd_ready", obs_ready, 1);
    chk("ext_rd_rvalid", bus.ext_rvalid, 1);
    chk("ext_rd_data", bus.ext_rdata, 32'hDEAD_BEEF);
    drive(1, 0, 32'h64, 0, 1, 0, 32'h14, 0, 1);
    cycle();
    chk("ext_rd_no_lock", obs_ready, 0);
    chk("ext_rd_rvalid_end", bus.ext_rvalid, 0);
    idle();

    // Starvation: core wins MAX_WAIT cycles, then ext takes one
    for (int i = 0; i < MAX_WAIT + 2; i++) begin
      drive(1, 0, 32'h8, 0, 1, 0, 32'h18, 0, 1);
      cycle();
      chk("starve_stall", obs_stall, (i == MAX_WAIT) ? 1 : 0);
    end
    idle();

    // Locked 3-beat write burst against a busy core
    b = 0; stalls = 0;
    for (int c = 0; c < 20 && b < 3; c++) begin
      drive(1, 0, 32'h40, 0, 1, 1, 32'h20 + 4 * b, 32'hA0 + b, b == 2);
      cycle();
      if (obs_stall) stalls++;
      if (obs_ready) b++;
    end
    chk("burst_beats", b, 3);
    chk("burst_stalls", stalls, 3);
    idle();
    for (int i = 0; i < 3; i++) chk("burst_mem", mem[8 + i], 32'hA0 + i);

    // Burst cap: 10-beat burst, lock released after beat MAX_BURST
    b = 0; stalls = 0; gap = 0;
    for (int c = 0; c < 60 && b < 10; c++) begin
      drive(1, 0, 32'h0, 0, 1, 1, 32'h100 + 4 * b, 32'hC0 + b, b == 9);
      cycle();
      if (obs_stall) stalls++;
      if (b == MAX_BURST && !obs_stall) gap++;
      if (obs_ready) b++;
    end
    chk("cap_beats", b, 10);
    chk("cap_stalls", stalls, 10);
    chk("cap_core_gap", gap, MAX_WAIT);
    idle();

    // Reset during beat 2 of a 4-beat read burst
    drive(0, 0, 0, 0, 1, 0, 32'h200, 0, 0);
    cycle();
    reset = 1'b0;
    model_reset();
    drive(1, 0, 32'h40, 0, 1, 0, 32'h204, 0, 0);
    cycle();
    chk("rstb_ready", obs_ready, 0);
    chk("rstb_rvalid", bus.ext_rvalid, 0);
    reset = 1'b1;
    drive(1, 0, 32'h64, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("rstb_core_stall", obs_stall, 0);
    chk("rstb_core_ld", obs_rdata, 32'h07);

    // Random traffic with occasional resets
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset = 1'b0;
        model_reset();
      end
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            32'($urandom_range(0, 15)) << 2, $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
            32'($urandom_range(0, 15)) << 2, $urandom,
            $urandom_range(0, 3) == 0);
      cycle();
      reset = 1'b1;
    end
    idle();

    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
    chk("final_mem_diffs", diffs, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single data memory between the core's load/store port and an external requester (DMA/debug loader). The core normally has priority. A starvation counter guarantees the external port service, and the external port can lock the memory for short bursts. While it is denied, the core is stalled through cpu_stall, which gates the PC register enable. The block sits between the core's data port and dmem inside top.

Parameters:
AW, 32, address width
DW, 32, data width
MAX_WAIT, 4, consecutive cycles ext may be denied while the core holds the memory (legal range >=1)
MAX_BURST, 8, maximum beats per locked external burst (legal range >=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cpu_req  in  1  core memory access this cycle (load or store)
cpu_we  in  1  core store enable
cpu_addr  in  AW  core byte address
cpu_wdata  in  DW  core store data
cpu_rdata  out  DW  load data to core, combinational
cpu_stall  out  1  core access not granted this cycle; core holds PC and state
ext_valid  in  1  external request valid
ext_we  in  1  external write enable
ext_addr  in  AW  external address
ext_wdata  in  DW  external write data
ext_last  in  1  final beat of the external burst
ext_ready  out  1  external beat accepted this cycle (combinational)
ext_rvalid  out  1  registered read data valid
ext_rdata  out  DW  registered read data
mem_we  out  1  dmem write enable
mem_a  out  AW  dmem address
mem_wd  out  DW  dmem write data
mem_rd  in  DW  dmem read data (combinational read; write on clk rising edge)

Behaviour:
- State: S_CPU (default) and S_EXT (burst lock).
- Registers: wait_cnt [0..MAX_WAIT] and beat_cnt [0..MAX_BURST].
- Per-cycle grant rules (combinational), exactly one owner:
  - S_CPU: ext is granted if ext_valid and (!cpu_req or wait_cnt==MAX_WAIT). Otherwise the core is granted.
  - S_EXT: ext is granted if ext_valid. If ext_valid is low (bubble), the core is granted and the state is held.
- Mux outputs:
  - If ext is granted: mem_a=ext_addr, mem_wd=ext_wdata, mem_we=ext_we.
  - Otherwise: mem_a=cpu_addr, mem_wd=cpu_wdata, mem_we=cpu_req&cpu_we.
- Combinational outputs:
  - ext_ready = ext grant.
  - cpu_stall = cpu_req & ~core grant.
  - cpu_rdata = mem_rd at all times.
- wait_cnt:
  - Increments, saturating, when ext_valid & cpu_req & core granted in S_CPU.
  - Clears when ext is granted or when ext_valid is low.
- Transitions:
  - S_CPU->S_EXT: ext beat accepted with ext_last=0 and MAX_BURST>1; beat_cnt set to 1.
  - In S_EXT, each accepted beat increments beat_cnt.
  - S_EXT->S_CPU: accepted beat has ext_last=1, or that beat makes beat_cnt==MAX_BURST. That beat is the last one granted; beat_cnt and wait_cnt clear.
  - Following a forced exit, remaining beats of the burst re-arbitrate in S_CPU.
- Read return: ext_rvalid=1 exactly one cycle after an accepted beat with ext_we=0; ext_rdata = mem_rd captured at acceptance. It stays high on back-to-back reads. Writes produce no rvalid.
- Simultaneous ext and core writes to the same address: only the granted one writes; the stalled core retries next cycle.
- Reset (asynchronous, reset=0):
  - State S_CPU, wait_cnt=0, beat_cnt=0, ext_rvalid=0, ext_rdata=0.
  - Combinational outputs follow the S_CPU rules.
  - Reset mid-burst aborts the burst; no rvalid is issued for a beat accepted in the reset cycle.
- Latency: core access has zero added latency when granted. External writes commit at the grant edge; external read data arrives 1 cycle after acceptance.

Test Plan:
- Core-only traffic: cpu_req=1, cpu_we=1, addr 0x64, data 0x07; ext idle -> mem_we=1, mem_a=0x64, cpu_stall never 1; a later load from 0x64 returns 0x07.
- Idle core, single ext read: ext_valid=1, ext_last=1, addr 0x10 (preloaded 0xDEADBEEF), cpu_req=0 -> ext_ready=1 same cycle; ext_rvalid=1 and ext_rdata=0xDEADBEEF next cycle; state stays S_CPU.
- Starvation: cpu_req=1 every cycle, ext_valid=1 continuously, MAX_WAIT=4 -> core granted 4 cycles, ext granted on the 5th with cpu_stall=1 for that cycle only, then wait_cnt=0.
- Locked burst: 3 ext writes to 0x20/0x24/0x28, ext_last on the 3rd, cpu_req=1 throughout -> cpu_stall=1 for exactly 3 cycles (first starts after the MAX_WAIT rule); memory holds all 3 words.
- Burst cap: MAX_BURST=8, 10-beat burst with ext_last only on beat 10 -> returns to S_CPU after beat 8; core is granted at least one cycle before beat 9 when cpu_req=1 and wait_cnt<MAX_WAIT.
- Reset mid-burst: assert reset=0 during beat 2 of a 4-beat read burst -> ext_rvalid=0 and ext_ready reflects the S_CPU rules; after release, a core load completes with cpu_stall=0.
